// File: rtl/rumble_scheduler.sv
// Shared rumble pulse-pattern scheduler: command FIFO feeding one on/off phase timer.
// Optional RUMBLE_PREEMPT_EN: urgent commands (cmdData[31]) bypass the FIFO and abort the active pattern.
//
// state | meaning
// IDLE  | no pattern; pops the FIFO head when an entry is waiting
// LOAD  | active command latched, pulse count seeded, on-phase timer loaded
// ON    | addressed player's motor driven until the timer expires
// OFF   | all motors low for the off phase, then next pulse or back to IDLE
module rumble_scheduler #(
  parameter int NUM_PLAYERS = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int UNIT_CYCLES = 50000
) (
  input  logic                          fastClock,
  input  logic                          reset,
  input  logic                          cmdValid,
  input  logic [31:0]                   cmdData,
  output logic                          cmdReady,
  input  logic                          cancelAll,
  output logic [NUM_PLAYERS-1:0]        motorOut,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TIMER_W = $clog2(255 * UNIT_CYCLES + 1);
  localparam int CMD_W   = 22;

  typedef enum logic [1:0] {IDLE, LOAD, ON, OFF} stateT;

  stateT              state, nextState;
  logic [CMD_W-1:0]   fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]   headPtr, tailPtr;
  logic [CMD_W-1:0]   headCmd, actCmd;
  logic [3:0]         remaining;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] onLen, offLen;
  logic               pushEn, popEn, dropCmd, urgentHit, timerDone, cmdInvalid;
  logic               unusedBits;

`ifdef RUMBLE_PREEMPT_EN
  assign urgentHit  = cmdValid && cmdData[31] && !cancelAll;
  assign unusedBits = ^cmdData[30:22];
`else
  assign urgentHit  = 1'b0;
  assign unusedBits = ^cmdData[31:22];
`endif

  // Timer counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [TIMER_W-1:0] phaseLen(input logic [7:0] units);
    logic [7:0] u;
    u = (units == 8'd0) ? 8'd1 : units;
    return TIMER_W'(u * UNIT_CYCLES - 1);
  endfunction

  assign onLen      = phaseLen(actCmd[13:6]);
  assign offLen     = phaseLen(actCmd[21:14]);
  assign timerDone  = (timer == '0);
  assign cmdInvalid = (actCmd[5:2] == 4'd0) || ({1'b0, actCmd[1:0]} >= 3'(NUM_PLAYERS));

  assign cmdReady = (fifoCount != CNT_W'(FIFO_DEPTH));
  assign pushEn   = cmdValid && cmdReady && !cancelAll && !urgentHit;
  assign dropCmd  = cmdValid && !cmdReady && !cancelAll && !urgentHit;
  assign headCmd  = fifoMem[headPtr];
  assign busy     = (state != IDLE);

  always_ff @(posedge fastClock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    popEn     = 1'b0;
    case (state)
      IDLE: if (fifoCount != '0) begin
        popEn     = 1'b1;
        nextState = LOAD;
      end
      LOAD: nextState = cmdInvalid ? IDLE : ON;
      ON:   if (timerDone) nextState = OFF;
      OFF:  if (timerDone) nextState = (remaining > 4'd1) ? ON : IDLE;
      default: nextState = IDLE;
    endcase
    if (urgentHit) begin
      popEn     = 1'b0;
      nextState = LOAD;
    end
    if (cancelAll) begin
      popEn     = 1'b0;
      nextState = IDLE;
    end
  end

  // An urgent command kills the drive in the very cycle it arrives.
  always_comb begin
    motorOut = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      motorOut[i] = (state == ON) && (actCmd[1:0] == 2'(i)) && !urgentHit;
  end

  always_ff @(posedge fastClock) begin
    if (reset) begin
      actCmd    <= '0;
      remaining <= '0;
      timer     <= '0;
    end else if (cancelAll) begin
      remaining <= '0;
      timer     <= '0;
    end else if (urgentHit) begin
      actCmd <= cmdData[CMD_W-1:0];
    end else begin
      if (popEn) actCmd <= headCmd;
      case (state)
        LOAD: begin
          remaining <= actCmd[5:2];
          timer     <= onLen;
        end
        ON: timer <= timerDone ? offLen : timer - 1'b1;
        OFF: begin
          if (timerDone) begin
            remaining <= remaining - 1'b1;
            timer     <= onLen;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge fastClock) begin
    if (pushEn) fifoMem[tailPtr] <= cmdData[CMD_W-1:0];
  end

  always_ff @(posedge fastClock) begin
    if (reset) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else if (cancelAll) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      fifoCount <= '0;
    end else begin
      if (pushEn) tailPtr <= tailPtr + 1'b1;
      if (popEn)  headPtr <= headPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: ;
      endcase
      if (dropCmd) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rumble_scheduler.sv
// Directed bench for rumble_scheduler with UNIT_CYCLES=4; cycle numbers are counted from the push cycle.
module tb_rumble_scheduler;
  logic        fastClock;
  logic        reset;
  logic        cmdValid;
  logic [31:0] cmdData;
  logic        cmdReady;
  logic        cancelAll;
  logic [3:0]  motorOut;
  logic        busy;
  logic [2:0]  fifoCount;
  logic        overflow;

  int nChecks = 0;
  int nFail   = 0;
  int riseCount [4];
  logic [3:0] expM;
  logic quiet;

  rumble_scheduler #(.NUM_PLAYERS(4), .FIFO_DEPTH(4), .UNIT_CYCLES(4)) dut (
    .fastClock(fastClock), .reset(reset), .cmdValid(cmdValid), .cmdData(cmdData),
    .cmdReady(cmdReady), .cancelAll(cancelAll), .motorOut(motorOut), .busy(busy),
    .fifoCount(fifoCount), .overflow(overflow)
  );

  initial fastClock = 1'b0;
  always #5 fastClock = ~fastClock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [31:0] mkCmd(input logic [1:0] pl, input logic [3:0] np,
                                        input logic [7:0] onU, input logic [7:0] offU, input logic urg);
    return {urg, 9'd0, offU, onU, np, pl};
  endfunction

  task automatic step();
    @(posedge fastClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs until the scheduler is idle with an empty FIFO, counting motor rising edges.
  task automatic waitIdle(input string tag, input int bound);
    logic [3:0] prev;
    logic done;
    prev = motorOut;
    done = 1'b0;
    for (int i = 0; i < 4; i++) riseCount[i] = 0;
    for (int n = 0; n < bound && !done; n++) begin
      step();
      for (int i = 0; i < 4; i++)
        if (motorOut[i] && !prev[i]) riseCount[i]++;
      prev = motorOut;
      if (!busy && fifoCount == 3'd0) done = 1'b1;
    end
    chk({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; cmdValid = 1'b0; cmdData = '0; cancelAll = 1'b0;
    repeat (3) step();
    chk("rst_motor", 32'(motorOut), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifoCount), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ready", 32'(cmdReady), 32'd1);
    reset = 1'b0;
    step();

    // Basic pattern: player 1, 2 pulses, on 1 unit, off 2 units
    cmdData = mkCmd(2'd1, 4'd2, 8'd1, 8'd2, 1'b0); cmdValid = 1'b1;
    step();
    cmdValid = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      if (c > 1) step();
      expM = ((c >= 3 && c <= 6) || (c >= 15 && c <= 18)) ? 4'b0010 : 4'b0000;
      chk($sformatf("t1_motor_c%0d", c), 32'(motorOut), 32'(expM));
      chk($sformatf("t1_busy_c%0d", c), 32'(busy), (c >= 2 && c <= 26) ? 32'd1 : 32'd0);
    end

    // Overflow: long pattern for player 0, then 5 back-to-back pushes
    cmdData = mkCmd(2'd0, 4'd1, 8'd8, 8'd1, 1'b0); cmdValid = 1'b1;
    step();
    cmdValid = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_count_k%0d", k), 32'(fifoCount), 32'(k));
      if (k == 4) begin
        chk("t2_ready_full", 32'(cmdReady), 32'd0);
        chk("t2_ovf_before", 32'(overflow), 32'd0);
      end
      cmdData = (k == 4) ? mkCmd(2'd3, 4'd1, 8'd1, 8'd1, 1'b0)
                         : mkCmd((k % 2 == 0) ? 2'd1 : 2'd2, 4'd1, 8'd1, 8'd1, 1'b0);
      cmdValid = 1'b1;
      step();
    end
    cmdValid = 1'b0;
    chk("t2_ovf_set", 32'(overflow), 32'd1);
    chk("t2_count_full", 32'(fifoCount), 32'd4);
    chk("t2_ready_after", 32'(cmdReady), 32'd0);
    waitIdle("t2_drain", 200);
    chk("t2_rises_p1", 32'(riseCount[1]), 32'd2);
    chk("t2_rises_p2", 32'(riseCount[2]), 32'd2);
    chk("t2_rises_p3", 32'(riseCount[3]), 32'd0);
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);

    // Zero-pulse command followed by a valid player-2 command
    cmdData = mkCmd(2'd1, 4'd0, 8'd1, 8'd1, 1'b0); cmdValid = 1'b1;
    step();
    chk("t3_count_c1", 32'(fifoCount), 32'd1);
    cmdData = mkCmd(2'd2, 4'd1, 8'd1, 8'd1, 1'b0);
    step();
    cmdValid = 1'b0;
    chk("t3_count_c2", 32'(fifoCount), 32'd1);
    chk("t3_busy_c2", 32'(busy), 32'd1);
    chk("t3_motor_c2", 32'(motorOut), 32'd0);
    for (int c = 3; c <= 13; c++) begin
      step();
      expM = (c >= 5 && c <= 8) ? 4'b0100 : 4'b0000;
      chk($sformatf("t3_motor_c%0d", c), 32'(motorOut), 32'(expM));
      chk($sformatf("t3_busy_c%0d", c), 32'(busy), (c >= 4 && c <= 12) ? 32'd1 : 32'd0);
      if (c == 3) chk("t3_count_c3", 32'(fifoCount), 32'd1);
    end

    // cancelAll mid-ON with two entries queued and a push in the same cycle
    cmdData = mkCmd(2'd0, 4'd1, 8'd4, 8'd1, 1'b0); cmdValid = 1'b1;
    step();
    cmdData = mkCmd(2'd1, 4'd1, 8'd1, 8'd1, 1'b0);
    step();
    cmdData = mkCmd(2'd2, 4'd1, 8'd1, 8'd1, 1'b0);
    step();
    cmdValid = 1'b0;
    repeat (2) step();
    chk("t4_motor_pre", 32'(motorOut), 32'h1);
    chk("t4_count_pre", 32'(fifoCount), 32'd2);
    cancelAll = 1'b1; cmdValid = 1'b1; cmdData = mkCmd(2'd3, 4'd1, 8'd1, 8'd1, 1'b0);
    step();
    cancelAll = 1'b0; cmdValid = 1'b0;
    chk("t4_motor", 32'(motorOut), 32'd0);
    chk("t4_count", 32'(fifoCount), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ovf_kept", 32'(overflow), 32'd1);
    chk("t4_ready", 32'(cmdReady), 32'd1);
    quiet = 1'b1;
    repeat (15) begin
      step();
      if (motorOut != 4'd0 || busy) quiet = 1'b0;
    end
    chk("t4_quiet", 32'(quiet), 32'd1);

    // Reset during OFF, then a fresh command
    cmdData = mkCmd(2'd1, 4'd2, 8'd1, 8'd2, 1'b0); cmdValid = 1'b1;
    step();
    cmdData = mkCmd(2'd2, 4'd1, 8'd1, 8'd1, 1'b0);
    step();
    cmdValid = 1'b0;
    repeat (7) step();
    chk("t5_motor_off", 32'(motorOut), 32'd0);
    chk("t5_busy_off", 32'(busy), 32'd1);
    chk("t5_count_off", 32'(fifoCount), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rst_motor", 32'(motorOut), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_count", 32'(fifoCount), 32'd0);
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    chk("t5_rst_ready", 32'(cmdReady), 32'd1);
    cmdData = mkCmd(2'd3, 4'd1, 8'd1, 8'd1, 1'b0); cmdValid = 1'b1;
    step();
    cmdValid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) step();
      expM = (c >= 3 && c <= 6) ? 4'b1000 : 4'b0000;
      chk($sformatf("t5_motor_c%0d", c), 32'(motorOut), 32'(expM));
      chk($sformatf("t5_busy_c%0d", c), 32'(busy), (c >= 2 && c <= 10) ? 32'd1 : 32'd0);
    end

`ifdef RUMBLE_PREEMPT_EN
    // Urgent player-3 command during player 0's ON phase
    cmdData = mkCmd(2'd0, 4'd1, 8'd4, 8'd1, 1'b0); cmdValid = 1'b1;
    step();
    cmdData = mkCmd(2'd1, 4'd1, 8'd1, 8'd1, 1'b0);
    step();
    step();
    cmdValid = 1'b0;
    repeat (2) step();
    chk("t6_motor_pre", 32'(motorOut), 32'h1);
    cmdData = mkCmd(2'd3, 4'd1, 8'd1, 8'd1, 1'b1); cmdValid = 1'b1;
    #1;
    chk("t6_motor_drop", 32'(motorOut), 32'd0);
    step();
    cmdValid = 1'b0;
    chk("t6_motor_load", 32'(motorOut), 32'd0);
    chk("t6_busy_load", 32'(busy), 32'd1);
    chk("t6_count_kept", 32'(fifoCount), 32'd2);
    step();
    chk("t6_motor_urgent", 32'(motorOut), 32'h8);
    waitIdle("t6_drain", 200);
    chk("t6_rises_p1", 32'(riseCount[1]), 32'd2);
    chk("t6_rises_p0", 32'(riseCount[0]), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
`else
    // Bit 31 set: command still queues through the FIFO
    cmdData = mkCmd(2'd1, 4'd1, 8'd1, 8'd1, 1'b1); cmdValid = 1'b1;
    step();
    cmdValid = 1'b0;
    chk("t6_urg_count", 32'(fifoCount), 32'd1);
    chk("t6_urg_busy", 32'(busy), 32'd0);
    step();
    chk("t6_urg_busy_load", 32'(busy), 32'd1);
    waitIdle("t6_drain", 100);
    chk("t6_urg_rises_p1", 32'(riseCount[1]), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
